// File: rtl/clefia_pkg.sv
// Shared definitions for the CLEFIA key-schedule constant generator.
// Holds the key-length encoding, FSM state type, default P/Q constants and
// initial T values, per-key-length word counts, and the two pure functions
// that define a constant word and the GF(2^16) x^-1 step.
package clefia_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'd0,
    KL_192 = 2'd1,
    KL_256 = 2'd2,
    KL_BAD = 2'd3
  } key_len_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [15:0] P_DEF     = 16'hB7E1;
  localparam logic [15:0] Q_DEF     = 16'h243F;
  localparam logic [15:0] IV128_DEF = 16'h428A;
  localparam logic [15:0] IV192_DEF = 16'h7137;
  localparam logic [15:0] IV256_DEF = 16'hB5C0;

  localparam logic [5:0] WORDS_128 = 6'd30;
  localparam logic [5:0] WORDS_192 = 6'd42;
  localparam logic [5:0] WORDS_256 = 6'd46;

  // Multiply by x^-1 modulo z^16+z^15+z^13+z^11+z^5+z^4+1.
  function automatic logic [15:0] mulinv(input logic [15:0] t);
    return t[0] ? ((t >> 1) ^ 16'hD418) : (t >> 1);
  endfunction

  // Two 32-bit CON values packed MSB first: {CON_2j, CON_2j+1}.
  function automatic logic [63:0] con_word(input logic [15:0] t,
                                           input logic [15:0] p = P_DEF,
                                           input logic [15:0] q = Q_DEF);
    return {t ^ p, {~t[14:0], ~t[15]}, ~t ^ q, {t[7:0], t[15:8]}};
  endfunction

  function automatic logic [5:0] word_count(input key_len_e kl);
    case (kl)
      KL_192:  return WORDS_192;
      KL_256:  return WORDS_256;
      default: return WORDS_128;
    endcase
  endfunction

endpackage

// File: rtl/clefia_con_lane.sv
// One combinational lane of the constant generator.
// Ports: t (current 16-bit T), word (64-bit constant word for t),
//        next_t (T for the following word index).
module clefia_con_lane
  import clefia_pkg::*;
#(
  parameter logic [15:0] P_CONST = P_DEF,
  parameter logic [15:0] Q_CONST = Q_DEF
) (
  input  logic [15:0] t,
  output logic [63:0] word,
  output logic [15:0] next_t
);

  assign word   = con_word(t, P_CONST, Q_CONST);
  assign next_t = mulinv(t);

endmodule

// File: rtl/clefia_con_gen.sv
// Streams CLEFIA key-schedule constants (30/42/46 words for 128/192/256-bit
// keys) over valid/ready, LANES words per beat, computing T on the fly.
// Ports: clk, rst (sync, active-high); start/key_len request a sequence;
//        busy while running; err pulses on an illegal key_len;
//        con_valid/con_ready handshake; con (LANES x 64-bit words, lane 0
//        lowest); con_idx word index of lane 0; con_last on the final beat.
module clefia_con_gen
  import clefia_pkg::*;
#(
  parameter int          LANES   = 1,
  parameter logic [15:0] P_CONST = P_DEF,
  parameter logic [15:0] Q_CONST = Q_DEF,
  parameter logic [15:0] IV128   = IV128_DEF,
  parameter logic [15:0] IV192   = IV192_DEF,
  parameter logic [15:0] IV256   = IV256_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            key_len,
  output logic                  busy,
  output logic                  err,
  output logic                  con_valid,
  input  logic                  con_ready,
  output logic [64*LANES-1:0]   con,
  output logic [5:0]            con_idx,
  output logic                  con_last
);

  state_e      state;
  logic [15:0] t_q;
  logic [5:0]  idx;
  logic [5:0]  n;
  logic [15:0] iv_sel;

  // T for each lane; t_chain[LANES] is T after a full beat.
  logic [15:0] t_chain [LANES+1];
  logic [63:0] words   [LANES];

  assign t_chain[0] = t_q;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    clefia_con_lane #(
      .P_CONST (P_CONST),
      .Q_CONST (Q_CONST)
    ) u_lane (
      .t      (t_chain[k]),
      .word   (words[k]),
      .next_t (t_chain[k+1])
    );
    assign con[64*k +: 64] = con_valid ? words[k] : 64'd0;
  end

  // NOTE: every signal written in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    iv_sel = IV128;
    case (key_len_e'(key_len))
      KL_192:  iv_sel = IV192;
      KL_256:  iv_sel = IV256;
      default: iv_sel = IV128;
    endcase
  end

  assign busy      = (state == S_RUN);
  assign con_valid = busy;
  assign con_idx   = con_valid ? idx : 6'd0;
  // 7-bit compare so idx + LANES cannot wrap before the comparison.
  assign con_last  = con_valid && (({1'b0, idx} + 7'(LANES)) == {1'b0, n});

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      t_q   <= 16'd0;
      idx   <= 6'd0;
      n     <= 6'd0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (key_len_e'(key_len) == KL_BAD) begin
              err <= 1'b1;
            end else begin
              t_q   <= iv_sel;
              idx   <= 6'd0;
              n     <= word_count(key_len_e'(key_len));
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // start is deliberately ignored here, including on the last beat.
          if (con_ready) begin
            t_q <= t_chain[LANES];
            idx <= idx + 6'(LANES);
            if (con_last) state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/clefia_con_gen.md
Name: clefia_con_gen

Overview:
- Sequential generator for the CLEFIA key-schedule constants for all three key lengths: 128-bit (30 x 64-bit words), 192-bit (42 words) and 256-bit (46 words).
- Computes the constants on the fly with the GF(2^16) x^-1 recurrence, so no per-key-length tables are stored.
- Streams the words to the key-schedule engine over a valid/ready interface, LANES words per beat.

Parameters:
- LANES, 1, 64-bit constant words per output beat; legal values are 1 and 2.
- P_CONST, 16'hB7E1, CLEFIA P constant.
- Q_CONST, 16'h243F, CLEFIA Q constant.
- IV128, 16'h428A, initial T for 128-bit keys.
- IV192, 16'h7137, initial T for 192-bit keys.
- IV256, 16'hB5C0, initial T for 256-bit keys.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a sequence; sampled only in IDLE.
- key_len  in  2  sampled with start: 0 = 128, 1 = 192, 2 = 256, 3 = illegal.
- busy  out  1  high while in RUN.
- err  out  1  one-cycle pulse on start with key_len = 3.
- con_valid  out  1  beat available.
- con_ready  in  1  consumer accepts the beat.
- con  out  64*LANES  constant words; lane k occupies bits [64k+63:64k]; lane 0 is the lowest word index.
- con_idx  out  6  word index of lane 0, counted from 0.
- con_last  out  1  marks the final beat of the sequence.

Behaviour:
- Reset (synchronous, active-high, clk domain):
  - Outputs: busy = 0, err = 0, con_valid = 0, con = 0, con_idx = 0, con_last = 0.
  - State goes to IDLE.
  - Reset asserted mid-sequence aborts the sequence immediately, with no final beat.
- FSM, two states, IDLE and RUN:
  - IDLE, start = 1 and key_len < 3: load T <= IV(key_len), idx <= 0, N <= 30/42/46; go to RUN. con_valid rises on the next cycle.
  - IDLE, start = 1 and key_len = 3: err = 1 for the following cycle; stay in IDLE.
  - RUN: con_valid = 1.
  - RUN, handshake (con_valid & con_ready): idx += LANES; T advances LANES steps.
  - RUN, handshake while con_last = 1: return to IDLE; con_valid = 0 on the next cycle.
  - start is ignored in RUN; key_len is ignored except when sampled with start.
- Word generation:
  - Word j uses T_j, where T_0 = IV and T_{j+1} = mulinv(T_j).
  - word = {T^P, rotl16(~T,1), ~T^Q, rotl16(T,8)}, MSB first, i.e. {CON_2j, CON_2j+1}.
  - mulinv(T) = T[0] ? ((T>>1) ^ 16'hD418) : (T>>1). This is x^-1 modulo z^16+z^15+z^13+z^11+z^5+z^4+1.
  - With LANES = 2, lane 1 uses mulinv(T) computed combinationally from the current T register.
- Beat timing:
  - Zero-bubble: one beat accepted per cycle while con_ready = 1.
  - First beat valid 1 cycle after start.
- Outputs per beat:
  - con = 0 whenever con_valid = 0.
  - con_last = con_valid & (idx + LANES == N).
  - All word counts are even, so LANES = 2 never yields a partial beat.
- Backpressure:
  - While con_valid & !con_ready, con, con_idx and con_last hold stable.
  - T and idx do not change while backpressured.
- Sequence completion:
  - start arriving on the same cycle as the last handshake is ignored; FSM state is still RUN on that edge.
  - After completion, a new start produces a fresh sequence from the IV.
- Widths:
  - All T arithmetic is exactly 16-bit.
  - idx is 6-bit; its maximum value is 46, so it never wraps.

Decomposition:
- Package clefia_pkg:
  - key-length enum (KL_128 = 0, KL_192 = 1, KL_256 = 2);
  - P/Q constants and the three IVs;
  - word counts 30/42/46;
  - function con_word(T) returning 64 bits;
  - function mulinv(T) returning 16 bits.
- Sub-module clefia_con_lane (combinational): input T; outputs the 64-bit word and next_T. Instantiated LANES times in a chain.
- The FSM, counter and handshake logic stay in the top module.

Test Plan:
1. LANES = 1, key_len = 0, con_ready = 1 -> beat 0 = F56B7AEB994A8A42 at idx 0; idx 1 = 96A4BD75FA854521; idx 29 = 1052B0987C73B3A7 with con_last = 1; exactly 30 beats; busy drops afterwards.
2. key_len = 1 -> idx 0 = C6D61D91AAF73771; 42 beats. key_len = 2 -> idx 0 = 0221947E6E00C0B5; 46 beats; last idx = 45.
3. Backpressure, key_len = 0: ready low for 5 cycles at idx 3 -> con = D5BC3B45B99D5D62 held stable with con_valid = 1; resumes at idx 4 = 52D73592 3EF636E5 (64'h52D735923EF636E5); all 30 words present in order, none duplicated.
4. LANES = 2, key_len = 0 -> beat 0 = {96A4BD75FA854521, F56B7AEB994A8A42}; 15 beats; con_idx = 0, 2, ..., 28; con_last on the 15th beat.
5. key_len = 3 start -> err pulses for one cycle; busy stays 0; no valid. start asserted during RUN -> sequence unaffected.
6. rst asserted at idx 10 -> all outputs 0 on the next cycle; a new start (key_len = 0) restarts at F56B7AEB994A8A42.
